// File: rtl/counter_cmd_sched_if.sv
// Requester command and response handshake bundle for counter_cmd_sched.
// The scheduler sits on the slave side; requesters and the response sink drive the master side.
interface counter_cmd_sched_if #(
  parameter int W    = 3,
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_cmd;
  logic [W*NREQ-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_q;
  logic              rsp_err;

  modport master (
    output req_valid, req_cmd, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_err
  );

  modport slave (
    input  req_valid, req_cmd, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_q, rsp_err
  );
endinterface

// File: rtl/counter_cmd_sched.sv
// Round-robin scheduler sharing one loadable up-counter between NREQ requesters.
// Executes CLEAR/FILL/LOAD/RUN-TO one at a time and returns one response per command.
module counter_cmd_sched #(
  parameter int W        = 3,
  parameter int NREQ     = 2,
  parameter int IDW      = 1,
  parameter int MAX_WAIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  counter_cmd_sched_if.slave  bus,
  output logic                ctr_reset,
  output logic                ctr_set,
  output logic                ctr_load,
  output logic [W-1:0]        ctr_data,
  input  logic [W-1:0]        ctr_q
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_FILL  = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_RUNTO = 2'b11;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, RUN, RESP} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q;
  logic [1:0]      cmd_q;
  logic [W-1:0]    data_q;
  logic [IDW-1:0]  id_q;
  logic [WCW-1:0]  waitCnt_q;
  logic [W-1:0]    rspQ_q;
  logic            rspErr_q;
  logic            strbReset_q, strbSet_q, strbLoad_q;
  logic [W-1:0]    ctrData_q;

  logic            grantAny;
  logic [NREQ-1:0] grantOneHot;
  logic [IDW-1:0]  grantIdx;
  logic [IDW-1:0]  grantNext;
  logic [1:0]      grantCmd;
  logic [W-1:0]    grantData;
  logic            accept;
  logic            runMatch;
  logic            runTimeout;

  function automatic int rrIndex(input logic [IDW-1:0] p, input int k);
    return (int'(p) + k) % NREQ;
  endfunction

  // Search outward from the pointer; the first valid requester wins.
  always_comb begin
    grantAny    = 1'b0;
    grantOneHot = '0;
    grantIdx    = '0;
    grantNext   = '0;
    grantCmd    = '0;
    grantData   = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grantAny && i == rrIndex(ptr_q, k) && bus.req_valid[i]) begin
          grantAny       = 1'b1;
          grantOneHot[i] = 1'b1;
          grantIdx       = IDW'(i);
          grantNext      = IDW'((i + 1) % NREQ);
          grantCmd       = bus.req_cmd[2*i +: 2];
          grantData      = bus.req_data[W*i +: W];
        end
      end
    end
  end

  assign accept     = |(bus.req_valid & bus.req_ready);
  assign runMatch   = (ctr_q == data_q);
  assign runTimeout = (waitCnt_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (grantCmd == CMD_RUNTO) ? RUN : ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RUN:     if (runMatch || runTimeout) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered at accept so exactly one is high in the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      id_q        <= '0;
      waitCnt_q   <= '0;
      rspQ_q      <= '0;
      rspErr_q    <= 1'b0;
      strbReset_q <= 1'b0;
      strbSet_q   <= 1'b0;
      strbLoad_q  <= 1'b0;
      ctrData_q   <= '0;
    end else begin
      strbReset_q <= 1'b0;
      strbSet_q   <= 1'b0;
      strbLoad_q  <= 1'b0;
      if (state_q == IDLE && accept) begin
        cmd_q       <= grantCmd;
        data_q      <= grantData;
        id_q        <= grantIdx;
        ptr_q       <= grantNext;
        waitCnt_q   <= '0;
        strbReset_q <= (grantCmd == CMD_CLEAR);
        strbSet_q   <= (grantCmd == CMD_FILL);
        strbLoad_q  <= (grantCmd == CMD_LOAD);
        if (grantCmd == CMD_LOAD) ctrData_q <= grantData;
      end
      if (state_q == CAPTURE) begin
        rspQ_q   <= ctr_q;
        rspErr_q <= 1'b0;
      end
      // A timeout reports the value seen in the last compared cycle.
      if (state_q == RUN) begin
        if (runMatch) begin
          rspQ_q   <= data_q;
          rspErr_q <= 1'b0;
        end else if (runTimeout) begin
          rspQ_q   <= ctr_q;
          rspErr_q <= 1'b1;
        end else begin
          waitCnt_q <= waitCnt_q + WCW'(1);
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE && !reset) ? grantOneHot : '0;
    bus.rsp_valid = (state_q == RESP) && !reset;
    bus.rsp_id    = id_q;
    bus.rsp_q     = rspQ_q;
    bus.rsp_err   = rspErr_q;
    ctr_reset     = reset | strbReset_q;
    ctr_set       = strbSet_q;
    ctr_load      = strbLoad_q;
    ctr_data      = ctrData_q;
  end

endmodule

// File: tb/tb_counter_cmd_sched.sv
// Directed self-checking bench for counter_cmd_sched with a behavioural counter model.
// The counter output can be pinned to a fixed value to exercise the RUN-TO timeout.
module tb_counter_cmd_sched;

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_FILL  = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_RUNTO = 2'b11;

  logic       clk;
  logic       reset;
  logic       ctr_reset, ctr_set, ctr_load;
  logic [2:0] ctr_data;
  logic [2:0] ctrQ;
  logic [2:0] cnt;
  logic       forceEn;
  logic [2:0] forceVal;

  int testsRun    = 0;
  int testsFailed = 0;

  counter_cmd_sched_if #(.W(3), .NREQ(2), .IDW(1)) bus ();

  counter_cmd_sched #(.W(3), .NREQ(2), .IDW(1), .MAX_WAIT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ctr_reset (ctr_reset),
    .ctr_set   (ctr_set),
    .ctr_load  (ctr_load),
    .ctr_data  (ctr_data),
    .ctr_q     (ctrQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared counter: reset > set > load > count, wrapping at 7.
  always @(posedge clk) begin
    if (ctr_reset)     cnt <= 3'd0;
    else if (ctr_set)  cnt <= 3'd7;
    else if (ctr_load) cnt <= ctr_data;
    else               cnt <= cnt + 3'd1;
  end

  assign ctrQ = forceEn ? forceVal : cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Present a command and return in the cycle after it was accepted.
  task automatic applyStimulus(input int id, input logic [1:0] cmd, input logic [2:0] data);
    int n;
    bus.req_valid[id]        = 1'b1;
    bus.req_cmd[2*id +: 2]   = cmd;
    bus.req_data[3*id +: 3]  = data;
    #1;
    n = 0;
    while (!bus.req_ready[id] && n < 40) begin
      tick();
      n++;
    end
    checkOutput("accept_wait", {31'd0, bus.req_ready[id]}, 32'd1);
    tick();
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic waitRsp(input int limit, output int n);
    n = 0;
    while (!bus.rsp_valid && n < limit) begin
      tick();
      n++;
    end
    checkOutput("rsp_wait", {31'd0, bus.rsp_valid}, 32'd1);
  endtask

  task automatic finishResponse();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checkOutput("rsp_drop", {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic runSimple(input int id, input logic [1:0] cmd, input logic [2:0] data, input logic [2:0] expQ);
    applyStimulus(id, cmd, data);
    checkOutput("strobe_reset", {31'd0, ctr_reset}, {31'd0, cmd == CMD_CLEAR});
    checkOutput("strobe_set",   {31'd0, ctr_set},   {31'd0, cmd == CMD_FILL});
    checkOutput("strobe_load",  {31'd0, ctr_load},  {31'd0, cmd == CMD_LOAD});
    if (cmd == CMD_LOAD) checkOutput("load_data", {29'd0, ctr_data}, {29'd0, data});
    tick();
    checkOutput("a2_strobes", {29'd0, ctr_reset, ctr_set, ctr_load}, 32'd0);
    if (cmd == CMD_LOAD) checkOutput("data_hold", {29'd0, ctr_data}, {29'd0, data});
    checkOutput("a2_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    checkOutput("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    checkOutput("rsp_id",    {31'd0, bus.rsp_id}, id[31:0]);
    checkOutput("rsp_q",     {29'd0, bus.rsp_q}, {29'd0, expQ});
    checkOutput("rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    finishResponse();
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    forceEn       = 1'b0;
    forceVal      = 3'd0;
    bus.req_valid = 2'b11;
    bus.req_cmd   = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;

    repeat (2) begin
      tick();
      checkOutput("rst_ctr_reset", {31'd0, ctr_reset}, 32'd1);
      checkOutput("rst_strobes",   {27'd0, ctr_set, ctr_load, ctr_data}, 32'd0);
      checkOutput("rst_rsp",       {26'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_q, bus.rsp_err}, 32'd0);
      checkOutput("rst_ready",     {30'd0, bus.req_ready}, 32'd0);
    end
    bus.req_valid = 2'b00;
    reset = 1'b0;
    #1;
    checkOutput("post_rst_ctr_reset", {31'd0, ctr_reset}, 32'd0);

    runSimple(0, CMD_LOAD,  3'd5, 3'd5);
    runSimple(1, CMD_FILL,  3'd0, 3'd7);
    runSimple(1, CMD_CLEAR, 3'd0, 3'd0);

    // Fairness with both requesters continuously valid.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_cmd   = {CMD_LOAD, CMD_LOAD};
    bus.req_data  = {3'd2, 3'd1};
    bus.req_valid = 2'b11;
    #1;
    for (int c = 0; c < 4; c++) begin
      n = 0;
      while (bus.req_ready == 2'b00 && n < 40) begin
        tick();
        n++;
      end
      checkOutput("ready_onehot", {31'd0, bus.req_ready == 2'b01 || bus.req_ready == 2'b10}, 32'd1);
      checkOutput("grant_order",  {31'd0, bus.req_ready[1]}, c % 2);
      tick();
      checkOutput("busy_ready", {30'd0, bus.req_ready}, 32'd0);
      tick();
      tick();
      checkOutput("fair_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      checkOutput("fair_rsp_id",    {31'd0, bus.rsp_id}, c % 2);
      checkOutput("fair_rsp_q",     {29'd0, bus.rsp_q}, (c % 2) + 1);
      if (c == 0) begin
        for (int s = 0; s < 5; s++) begin
          tick();
          checkOutput("stall_ready", {30'd0, bus.req_ready}, 32'd0);
          checkOutput("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
          checkOutput("stall_id",    {31'd0, bus.rsp_id}, 32'd0);
          checkOutput("stall_q",     {29'd0, bus.rsp_q}, 32'd1);
          checkOutput("stall_err",   {31'd0, bus.rsp_err}, 32'd0);
        end
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      checkOutput("fair_rsp_drop", {31'd0, bus.rsp_valid}, 32'd0);
    end
    bus.req_valid = 2'b00;
    #1;

    // RUN-TO across the counter wrap.
    runSimple(0, CMD_LOAD, 3'd6, 3'd6);
    applyStimulus(0, CMD_RUNTO, 3'd2);
    checkOutput("run_no_strobe", {29'd0, ctr_reset, ctr_set, ctr_load}, 32'd0);
    waitRsp(20, n);
    checkOutput("run_within_wrap", {31'd0, n <= 8}, 32'd1);
    checkOutput("run_rsp_q",   {29'd0, bus.rsp_q}, 32'd2);
    checkOutput("run_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    checkOutput("run_rsp_id",  {31'd0, bus.rsp_id}, 32'd0);
    finishResponse();

    // RUN-TO timeout with the counter pinned at 3.
    forceEn  = 1'b1;
    forceVal = 3'd3;
    applyStimulus(1, CMD_RUNTO, 3'd4);
    waitRsp(40, n);
    checkOutput("timeout_cycles", n[31:0], 32'd16);
    checkOutput("timeout_err",    {31'd0, bus.rsp_err}, 32'd1);
    checkOutput("timeout_q",      {29'd0, bus.rsp_q}, 32'd3);
    checkOutput("timeout_id",     {31'd0, bus.rsp_id}, 32'd1);
    finishResponse();

    // Reset in the middle of a repeated RUN-TO drops it silently.
    applyStimulus(1, CMD_RUNTO, 3'd4);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    checkOutput("midrst_ctr_reset", {31'd0, ctr_reset}, 32'd1);
    tick();
    tick();
    reset   = 1'b0;
    forceEn = 1'b0;
    n = 0;
    for (int s = 0; s < 20; s++) begin
      tick();
      if (bus.rsp_valid) n++;
    end
    checkOutput("midrst_no_rsp", n[31:0], 32'd0);
    bus.req_valid = 2'b11;
    #1;
    checkOutput("midrst_idle_grant0", {30'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 2'b00;
    #1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
